// File: rtl/i2s_to_wb_tx_serializer.sv
// I2S TX serializer: SCK/WS/SD from i2s_clk_i, 32-bit slots MSB first, WS leads MSB by one SCK.
// Pair latched at each pos-63 SCK fall, level ack; a missing/stale pair plays zeros and sets sticky underrun.
module i2s_to_wb_tx_serializer #(
  parameter int SCK_DIV = 4
) (
  input  logic        i2s_clk_i,
  input  logic        i2s_rst_i,
  input  logic        i2s_enable,
  input  logic        fifo_ready,
  input  logic [31:0] fifo_left_data,
  input  logic [31:0] fifo_right_data,
  output logic        fifo_ack,
  output logic        i2s_sck_o,
  output logic        i2s_ws_o,
  output logic        i2s_sd_o,
  output logic        i2s_ws_edge,
  output logic        underrun_error
);

  localparam int DW = $clog2(SCK_DIV) + 1;
  localparam int EW = $clog2(2 * SCK_DIV) + 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(SCK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LEN = EW'(2 * SCK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [EW-1:0] edge_cnt;
  logic [5:0]    pos;
  logic [31:0]   left_q;
  logic [31:0]   right_q;
  logic [31:0]   right_pend;

  logic       div_wrap;
  logic       fall;
  logic [5:0] pos_nxt;
  logic       ws_nxt;
  logic       sd_nxt;
  logic       latch;
  logic       take;

  always_comb begin
    div_wrap = (div_cnt == DIV_MAX);
    fall     = div_wrap && i2s_sck_o;
    pos_nxt  = pos + 6'd1;
    ws_nxt   = (pos_nxt >= 6'd31) && (pos_nxt <= 6'd62);
    // Both halves index with 31 - pos[4:0]: left for pos 0..31, right for 32..63.
    sd_nxt   = pos_nxt[5] ? right_q[5'd31 - pos_nxt[4:0]] : left_q[5'd31 - pos_nxt[4:0]];
    latch    = fall && (pos_nxt == 6'd63);
    take     = latch && fifo_ready && !fifo_ack;
  end

  always_ff @(posedge i2s_clk_i) begin
    if (i2s_rst_i || !i2s_enable) begin
      div_cnt        <= '0;
      edge_cnt       <= '0;
      pos            <= 6'd62;
      left_q         <= '0;
      right_q        <= '0;
      right_pend     <= '0;
      fifo_ack       <= 1'b0;
      i2s_sck_o      <= 1'b0;
      i2s_ws_o       <= 1'b0;
      i2s_sd_o       <= 1'b0;
      i2s_ws_edge    <= 1'b0;
      underrun_error <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt   <= '0;
        i2s_sck_o <= ~i2s_sck_o;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall) begin
        pos      <= pos_nxt;
        i2s_ws_o <= ws_nxt;
        i2s_sd_o <= sd_nxt;
        if (pos_nxt == 6'd0)
          right_q <= right_pend;
        if (latch) begin
          if (take) begin
            left_q     <= fifo_left_data;
            right_pend <= fifo_right_data;
          end else begin
            left_q         <= '0;
            right_pend     <= '0;
            underrun_error <= 1'b1;
          end
        end
      end

      if (take)
        fifo_ack <= 1'b1;
      else if (!fifo_ready)
        fifo_ack <= 1'b0;

      // Pulse stays up for 2*SCK_DIV clocks: loaded with len-1, dropped once the count is spent.
      if (fall && (ws_nxt != i2s_ws_o)) begin
        i2s_ws_edge <= 1'b1;
        edge_cnt    <= EDGE_LEN;
      end else if (edge_cnt != '0) begin
        edge_cnt <= edge_cnt - 1'b1;
      end else begin
        i2s_ws_edge <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_to_wb_tx_serializer.sv
// Directed + randomized bench for i2s_to_wb_tx_serializer (SCK_DIV = 2, 256-clock frames).
// Reference: closed-form timing from clocks-since-enable plus a queue of latched frame words.
module tb_i2s_to_wb_tx_serializer;

  localparam int SCK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ready;
  logic [31:0] ld;
  logic [31:0] rd;
  logic        ack;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        ws_edge;
  logic        under;

  always #5 clk = ~clk;

  i2s_to_wb_tx_serializer #(.SCK_DIV(SCK_DIV)) dut (
    .i2s_clk_i      (clk),
    .i2s_rst_i      (rst),
    .i2s_enable     (en),
    .fifo_ready     (ready),
    .fifo_left_data (ld),
    .fifo_right_data(rd),
    .fifo_ack       (ack),
    .i2s_sck_o      (sck),
    .i2s_ws_o       (ws),
    .i2s_sd_o       (sd),
    .i2s_ws_edge    (ws_edge),
    .underrun_error (under)
  );

  int          errors = 0;
  int          checks = 0;
  int          c = 0;
  bit          m_ack = 0;
  bit          m_under = 0;
  logic [63:0] frames[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (clk_since_enable=%0d)", tag, obs, exp, c);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare every output.
  task automatic tick();
    bit   idle, latch, take;
    int   k, f, p;
    logic e_sck, e_ws, e_sd, e_edge;
    @(posedge clk);
    idle = rst || !en;
    if (idle) begin
      c = 0; m_ack = 0; m_under = 0;
      frames.delete();
    end else begin
      c++;
      k = c / 4;
      latch = (c % 4 == 0) && ((k - 1) % 64 == 0);
      take  = latch && ready && !m_ack;
      if (latch) begin
        if (take) frames.push_back({ld, rd});
        else begin
          frames.push_back(64'd0);
          m_under = 1;
        end
      end
      if (take) m_ack = 1;
      else if (!ready) m_ack = 0;
    end
    #1;
    e_sck = 0; e_ws = 0; e_sd = 0; e_edge = 0;
    if (!idle) begin
      k = c / 4;
      e_sck = ((c / 2) % 2) == 1;
      if (k >= 2) begin
        f = (k - 2) / 64;
        p = (k - 2) % 64;
        e_ws   = (p >= 31) && (p <= 62);
        e_edge = (p == 31) || (p == 63);
        if (f < frames.size()) e_sd = frames[f][63 - p];
        else e_sd = 1'bx;
      end
    end
    chk("ack", ack, m_ack);
    chk("sck", sck, e_sck);
    chk("ws", ws, e_ws);
    chk("sd", sd, e_sd);
    chk("ws_edge", ws_edge, e_edge);
    chk("underrun", under, m_under);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int target;
    rst = 1; en = 0; ready = 0; ld = '0; rd = '0;
    run(3);
    rst = 0;
    run(3);

    // Basic frame: ack must appear at clock 4.
    en = 1; ready = 1; ld = 32'hA5A50001; rd = 32'h80000003;
    run(3);
    chk("ack_before_clk4", ack, 1'b0);
    run(1);
    chk("ack_at_clk4", ack, 1'b1);

    // Handshake: ack held while ready stays high, clears after ready drops.
    run(20);
    chk("ack_held_20", ack, 1'b1);
    ready = 0;
    run(1);
    chk("ack_cleared", ack, 1'b0);
    run(60);
    ready = 1; ld = $urandom; rd = $urandom;
    run(265 - c);
    chk("pair2_ack", ack, 1'b1);
    chk("pair2_no_underrun", under, 1'b0);
    ready = 0;

    // Underrun: nothing offered at the next latch.
    run(520 - c);
    chk("underrun_set", under, 1'b1);
    chk("underrun_ack_low", ack, 1'b0);
    run(600 - c);
    ready = 1; ld = $urandom; rd = $urandom;
    run(776 - c);
    chk("valid_after_underrun_ack", ack, 1'b1);
    chk("underrun_sticky", under, 1'b1);

    // Stale ready: ack never completes, so the following latch sees ready with ack high.
    run(1032 - c);
    chk("stale_ack_still_high", ack, 1'b1);
    ready = 0;
    run(1193 - c);

    // Disable at pos 40, then re-enable.
    en = 0;
    run(1);
    chk("disable_ack", ack, 1'b0);
    chk("disable_underrun", under, 1'b0);
    run(3);
    en = 1; ready = 1; ld = $urandom; rd = $urandom;
    run(4);
    chk("reenable_ack_clk4", ack, 1'b1);

    for (int i = 0; i < 3; i++) begin
      run($urandom_range(1, 40));
      ready = 0;
      run($urandom_range(1, 100));
      ready = 1; ld = $urandom; rd = $urandom;
      target = 4 + 256 * (i + 1);
      run(target - c + 2);
      chk("rand_frame_ack", ack, 1'b1);
      chk("rand_frame_no_underrun", under, 1'b0);
    end
    ready = 0;
    run(300);

    // Mid-frame reset, then enable held low.
    rst = 1;
    run(1);
    chk("rst_sck", sck, 1'b0);
    rst = 0; en = 0;
    run(5);
    chk("idle_ws", ws, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
